// File: rtl/bitwise_logic_pipe_pkg.sv
// ============================================================================
// logic_pkg : op-code enum and pipeline limits shared by bitwise_logic_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package logic_pkg;

  localparam int unsigned DEPTH_MAX = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_ANDN = 3'b111
  } logic_op_e;

endpackage

`default_nettype wire

// File: rtl/bitwise_logic_pipe_if.sv
// ============================================================================
// bitwise_logic_pipe_if : request/result handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface bitwise_logic_pipe_if #(
  parameter int WIDTH = `INSTRUCTION_WIDTH
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic [2:0]       op;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero_flag;
  logic [CW-1:0]    popcount;

  modport master (
    output in_valid, in_0, in_1, op, acc_sel, out_ready,
    input  in_ready, out_valid, out, zero_flag, popcount
  );

  modport slave (
    input  in_valid, in_0, in_1, op, acc_sel, out_ready,
    output in_ready, out_valid, out, zero_flag, popcount
  );
endinterface

`default_nettype wire

// File: rtl/bitwise_logic_pipe_popcount.sv
// ============================================================================
// popcount : combinational count of set bits
// Rev 1.0
// ============================================================================
`default_nettype none

module popcount #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0]           i_data,
  output logic      [$clog2(WIDTH+1)-1:0] o_count
);
  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end
endmodule

`default_nettype wire

// File: rtl/bitwise_logic_pipe.sv
// ============================================================================
// bitwise_logic_pipe : elastic DEPTH-stage bitwise ALU with accumulator operand
// Rev 1.0
// ============================================================================
`default_nettype none

module bitwise_logic_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = `INSTRUCTION_WIDTH,
  parameter int DEPTH = 2
) (
  input wire logic           clk,
  input wire logic           rst_n,
  bitwise_logic_pipe_if.slave bus
);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NSTG = (DEPTH > int'(DEPTH_MAX)) ? int'(DEPTH_MAX) : ((DEPTH < 1) ? 1 : DEPTH);

  logic [NSTG-1:0]  r_valid;
  logic [NSTG-1:0]  w_ld;
  logic             w_full;
  logic             w_interlock;
  logic             w_accept;
  logic             w_deliver;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_last_d;
  logic             w_last_v;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    r_pop;
  logic             r_zero;

  // Stage k may load whenever some stage at or beyond k is empty, or the consumer takes the result.
  always_comb begin
    w_ld   = '0;
    w_full = 1'b1;
    for (int k = 0; k < NSTG; k++) begin
      w_full = 1'b1;
      for (int j = k; j < NSTG; j++) begin
        w_full = w_full & r_valid[j];
      end
      w_ld[k] = bus.out_ready | ~w_full;
    end
  end

  assign w_interlock  = bus.in_valid & bus.acc_sel & (|r_valid);
  assign bus.in_ready = rst_n & w_ld[0] & ~w_interlock;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_deliver    = r_valid[NSTG-1] & bus.out_ready;
  assign w_a          = bus.acc_sel ? r_acc : bus.in_0;

  always_comb begin
    w_res = '0;
    case (logic_op_e'(bus.op))
      OP_AND:  w_res = w_a & bus.in_1;
      OP_OR:   w_res = w_a | bus.in_1;
      OP_XOR:  w_res = w_a ^ bus.in_1;
      OP_NOT:  w_res = ~w_a;
      OP_NAND: w_res = ~(w_a & bus.in_1);
      OP_NOR:  w_res = ~(w_a | bus.in_1);
      OP_XNOR: w_res = ~(w_a ^ bus.in_1);
      OP_ANDN: w_res = w_a & ~bus.in_1;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (w_ld[0]) r_valid[0] <= w_accept;
      for (int k = 1; k < NSTG; k++) begin
        if (w_ld[k]) r_valid[k] <= r_valid[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_d;
    logic             w_v;

    if (k == 0) begin : g_src_head
      assign w_d = w_res;
      assign w_v = w_accept;
    end else begin : g_src_prev
      assign w_d = g_stage[k-1].r_data;
      assign w_v = r_valid[k-1];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data <= '0;
      end else if (w_ld[k] && w_v) begin
        r_data <= w_d;
      end
    end
  end

  // Flags are derived from the value entering the last stage so they update with it.
  assign w_last_d = g_stage[NSTG-1].w_d;
  assign w_last_v = g_stage[NSTG-1].w_v;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .i_data  (w_last_d),
    .o_count (w_pop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_pop  <= '0;
    end else if (w_ld[NSTG-1] && w_last_v) begin
      r_zero <= (w_last_d == '0);
      r_pop  <= w_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_deliver) begin
      r_acc <= g_stage[NSTG-1].r_data;
    end
  end

  assign bus.out_valid = r_valid[NSTG-1];
  assign bus.out       = g_stage[NSTG-1].r_data;
  assign bus.zero_flag = r_zero;
  assign bus.popcount  = r_pop;

endmodule

`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
// ============================================================================
// tb_bitwise_logic_pipe : directed + random scoreboard bench for bitwise_logic_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bitwise_logic_pipe;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic        acc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk;
  logic rst_n;

  bitwise_logic_pipe_if #(.WIDTH(32)) bus ();

  bitwise_logic_pipe #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic        prev_rst;
  logic [31:0] m_acc;
  req_t        req_q[$];
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  logic [31:0] dlog[$];
  logic [31:0] elog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  tt;
    logic [31:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0011;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b0100;
    endcase
    for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic push_req(input logic acc, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.acc = acc; r.op = op; r.a = a; r.b = b;
    req_q.push_back(r);
  endtask

  task automatic tick(input logic rn, input logic ordy);
    req_t        r;
    logic        iv;
    logic        exp_rdy;
    logic        ev;
    logic [31:0] e;
    @(negedge clk);
    iv = (req_q.size() > 0);
    r  = iv ? req_q[0] : '0;
    rst_n         = rn;
    bus.in_valid  = iv;
    bus.acc_sel   = r.acc;
    bus.op        = r.op;
    bus.in_0      = r.a;
    bus.in_1      = r.b;
    bus.out_ready = ordy;
    #2;
    if (prev_rst) begin
      chk("rst_out", 64'(bus.out), 64'(0));
      chk("rst_zero", 64'(bus.zero_flag), 64'(0));
      chk("rst_pop", 64'(bus.popcount), 64'(0));
    end
    exp_rdy = rn && (ordy || exp_q.size() < DEPTH) && !(iv && r.acc && exp_q.size() > 0);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    ev = (exp_q.size() > 0) && (cyc >= acc_cyc_q[0] + DEPTH);
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev) begin
      e = exp_q[0];
      chk("out", 64'(bus.out), 64'(e));
      chk("zero_flag", 64'(bus.zero_flag), 64'(e == 32'd0));
      chk("popcount", 64'(bus.popcount), 64'($countones(e)));
    end
    if (rn) begin
      if (ev && ordy) begin
        dlog.push_back(bus.out);
        m_acc = exp_q.pop_front();
        void'(acc_cyc_q.pop_front());
      end
      if (iv && exp_rdy) begin
        exp_q.push_back(ref_op(r.op, r.acc ? m_acc : r.a, r.b));
        acc_cyc_q.push_back(cyc);
        void'(req_q.pop_front());
      end
    end else begin
      exp_q.delete();
      acc_cyc_q.delete();
      m_acc = 32'd0;
    end
    prev_rst = !rn;
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && n < 100) begin
      tick(1'b1, 1'b1);
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(req_q.size() + exp_q.size()), 64'(0));
  endtask

  task automatic check_log(input string tag);
    logic [31:0] got;
    chk({tag, "_count"}, 64'(dlog.size()), 64'(elog.size()));
    for (int i = 0; i < elog.size(); i++) begin
      got = (i < dlog.size()) ? dlog[i] : 32'hxxxx_xxxx;
      chk(tag, 64'(got), 64'(elog[i]));
    end
    dlog.delete();
    elog.delete();
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.acc_sel = 1'b0; bus.op = 3'd0;
    bus.in_0 = '0; bus.in_1 = '0; bus.out_ready = 1'b0;
    m_acc = '0;
    repeat (2) @(posedge clk);
    prev_rst = 1'b1;
    tick(1'b0, 1'b1);

    // Accumulator starts at zero: acc OR 0 must give 0.
    push_req(1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0);
    drain("acc_init");
    elog.push_back(32'h0);
    check_log("acc_init_out");

    // All eight ops back to back.
    for (int op = 0; op < 8; op++) push_req(1'b0, 3'(op), 32'hF0F0_F0F0, 32'hFF00_FF00);
    drain("ops");
    elog = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0F0F_0F0F,
             32'h0FFF_0FFF, 32'h000F_000F, 32'hF00F_F00F, 32'h00F0_00F0};
    check_log("ops_out");

    // Zero result and full popcount.
    push_req(1'b0, 3'd2, 32'h1234_5678, 32'h1234_5678);
    push_req(1'b0, 3'd3, 32'h0, 32'h5555_5555);
    drain("flags");
    elog = '{32'h0, 32'hFFFF_FFFF};
    check_log("flags_out");

    // Output backpressure with three requests queued.
    push_req(1'b0, 3'd0, 32'hAAAA_5555, 32'hFFFF_0000);
    push_req(1'b0, 3'd1, 32'h0000_0001, 32'h8000_0000);
    push_req(1'b0, 3'd6, 32'h1357_9BDF, 32'h0246_8ACE);
    repeat (5) tick(1'b1, 1'b0);
    drain("stall");
    elog = '{32'hAAAA_0000, 32'h8000_0001, ~(32'h1357_9BDF ^ 32'h0246_8ACE)};
    check_log("stall_out");

    // Accumulator dependency interlock.
    push_req(1'b0, 3'd0, 32'h0000_FFFF, 32'hFFFF_FFFF);
    push_req(1'b1, 3'd1, 32'h0, 32'hFFFF_0000);
    drain("interlock");
    elog = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    check_log("interlock_out");

    // Reset with two requests in flight.
    push_req(1'b0, 3'd1, 32'h1111_1111, 32'h2222_2222);
    push_req(1'b0, 3'd1, 32'h4444_4444, 32'h8888_8888);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    dlog.delete();
    push_req(1'b1, 3'd1, 32'h0, 32'h0);
    drain("midrst");
    elog.push_back(32'h0);
    check_log("midrst_out");

    // Randomized traffic with backpressure, acc operands and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (req_q.size() < 2 && $urandom_range(0, 3) != 0)
        push_req($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0);
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 Parameter WIDTH, default `INSTRUCTION_WIDTH (32), operand/result width in bits, SHALL be >= 8.
REQ-002 Parameter DEPTH, default 2, pipeline stages from accept to output, legal range 1..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 in_valid  in  1  request valid.
REQ-006 in_ready  out  1  block accepts request this cycle.
REQ-007 in_0, in_1  in  WIDTH  operands.
REQ-008 op  in  3  operation: 000 AND, 001 OR, 010 XOR, 011 NOT(a), 100 NAND, 101 NOR, 110 XNOR, 111 ANDN (a & ~b).
REQ-009 acc_sel  in  1  1 = use accumulator in place of in_0 as operand a.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out  out  WIDTH  result.
REQ-013 zero_flag  out  1  out == 0.
REQ-014 popcount  out  $clog2(WIDTH+1)  number of 1 bits in out.

Function
REQ-015 Request accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-016 Operation, operand capture and acc substitution SHALL occur at accept; result, zero_flag, popcount appear DEPTH cycles after accept with no stall.
REQ-017 Throughput one request per cycle when out_ready held high and acc_sel = 0.
REQ-018 Pipeline is elastic: stage k advances when stage k+1 is empty or advancing; last stage holds while out_valid && !out_ready.
REQ-019 out, zero_flag, popcount SHALL stay stable while out_valid && !out_ready.
REQ-020 in_ready = (stage 0 empty or advancing) AND NOT interlock.
REQ-021 Interlock: when in_valid && acc_sel and any stage is valid, in_ready SHALL be 0 until the pipeline is empty.
REQ-022 Accumulator (WIDTH bits) SHALL load out on every output handshake, regardless of acc_sel.
REQ-023 op 011 ignores in_1; out = ~a.
REQ-024 zero_flag and popcount SHALL be computed from the final-stage result, registered with it.
REQ-025 Output and input handshakes in the same cycle SHALL both complete; no bubble inserted.
REQ-026 in_ready SHALL NOT depend combinationally on out_ready through more than the stage-advance chain; no dependency on in_valid except via acc_sel interlock.
REQ-027 A request presented with in_ready = 0 SHALL be ignored; sender holds it.

Reset
REQ-028 On rst_n = 0 at a clock edge: all stage valids 0, out_valid 0, out 0, zero_flag 0, popcount 0, accumulator 0.
REQ-029 in_ready SHALL be 0 during reset and 1 in the first cycle after rst_n rises.
REQ-030 Reset mid-operation SHALL discard all in-flight requests; none delivered afterwards.

Structure
REQ-031 Package logic_pkg SHALL hold enum logic_op_e (3-bit op codes) and DEPTH_MAX = 4.
REQ-032 Sub-module popcount (parameter WIDTH, combinational) SHALL compute the bit count; instantiated once in the final stage.
REQ-033 Stage storage SHALL be generate-based arrays indexed 0..DEPTH-1.

Verification (WIDTH=32, DEPTH=2)
REQ-034 in_0=F0F0F0F0, in_1=FF00FF00, ops 000..111 back-to-back, out_ready=1 -> outs F000F000, FFF0FFF0, 0FF00FF0, 0F0F0F0F, 0FFF0FFF, 000F000F, F00FF00F, 00F000F0 on 8 consecutive cycles starting 2 cycles after first accept.
REQ-035 XOR in_0=in_1=12345678 -> out 0, zero_flag 1, popcount 0; NOT of 0 -> FFFFFFFF, popcount 32.
REQ-036 out_ready low 5 cycles with 3 requests issued -> in_ready drops after pipeline + output fill, out stable, all 3 delivered in order once out_ready rises.
REQ-037 AND 0000FFFF,FFFFFFFF then acc_sel=1 OR in_1=FFFF0000 -> in_ready low until first result taken, second out FFFFFFFF.
REQ-038 Reset asserted with 2 requests in flight -> out_valid 0 next cycle, accumulator 0, no stale result after release.
